// File: rtl/stopwatch_pkg.sv
// Stopwatch shared definitions: FSM encoding, time field widths and wrap limits.
// The LAP state exists only when STOPWATCH_LAP_EN is defined.
package stopwatch_pkg;

    localparam int CS_MAX  = 99;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    localparam int HR_W  = 5;
    localparam int MIN_W = 6;
    localparam int SEC_W = 6;
    localparam int CS_W  = 7;

`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;
`endif

    typedef struct packed {
        logic [HR_W-1:0]  hr;
        logic [MIN_W-1:0] mn;
        logic [SEC_W-1:0] sc;
        logic [CS_W-1:0]  cs;
    } sw_time_t;

    function automatic logic is_counting(state_t s);
`ifdef STOPWATCH_LAP_EN
        return (s == ST_RUN) || (s == ST_LAP);
`else
        return (s == ST_RUN);
`endif
    endfunction

    // >= rather than == so a corrupted field still wraps back into range
    function automatic sw_time_t time_inc(sw_time_t t);
        sw_time_t n;
        n = t;
        if (t.cs >= CS_W'(CS_MAX)) begin
            n.cs = '0;
            if (t.sc >= SEC_W'(SEC_MAX)) begin
                n.sc = '0;
                if (t.mn >= MIN_W'(MIN_MAX)) begin
                    n.mn = '0;
                    n.hr = (t.hr >= HR_W'(HR_MAX)) ? '0 : t.hr + 1'b1;
                end else begin
                    n.mn = t.mn + 1'b1;
                end
            end else begin
                n.sc = t.sc + 1'b1;
            end
        end else begin
            n.cs = t.cs + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector on a registered, already-debounced level; pulse one cycle after the input rises.
// No backpressure: the pulse lasts exactly one cycle and is consumed or lost.
module button_edge_detect (
    input  logic clock,
    input  logic reset_n,
    input  logic i_level,
    output logic o_rise
);

    logic r_in;
    logic r_prev;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_in   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_in   <= i_level;
            r_prev <= r_in;
        end
    end

    assign o_rise = r_in & ~r_prev;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch HH:MM:SS.CC with start/stop and lap/clear buttons; commands act 2 edges after a button rises, display is registered.
// Lap freeze is built only with STOPWATCH_LAP_EN; no backpressure, refresh output free-runs.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             btn_start_stop,
    input  logic             btn_lap_reset,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic [CS_W-1:0]  centiseconds,
    output logic             clock_refresh,
    output logic             running,
    output logic             lap_hold
);

    localparam int DIV  = CLK_HZ / 100;
    localparam int HALF = CLK_HZ / (2 * REFRESH_HZ);
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RF_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
    localparam logic [RF_W-1:0] RF_LAST = RF_W'(HALF - 1);

    logic            w_ss;
    logic            w_lr;
    state_t          r_state;
    state_t          w_state_next;
    logic            w_clear;
    logic            w_active;
    logic            w_tick;
    logic [PS_W-1:0] r_ps;
    sw_time_t        r_live;
    sw_time_t        w_live_next;
    sw_time_t        w_disp;
    logic [RF_W-1:0] r_rf_cnt;
    logic            r_refresh;

    button_edge_detect u_ss_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .i_level (btn_start_stop),
        .o_rise  (w_ss)
    );

    button_edge_detect u_lr_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .i_level (btn_lap_reset),
        .o_rise  (w_lr)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // start_stop is tested first in every state, so it wins over a simultaneous lap_reset
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_ss) begin
                    w_state_next = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                end else if (w_lr) begin
                    w_state_next = ST_LAP;
`endif
                end
            end
            ST_PAUSE: begin
                if (w_ss) begin
                    w_state_next = ST_RUN;
                end else if (w_lr) begin
                    w_state_next = ST_IDLE;
                    w_clear      = 1'b1;
                end
            end
`ifdef STOPWATCH_LAP_EN
            ST_LAP: begin
                if (w_ss) begin
                    w_state_next = ST_PAUSE;
                end else if (w_lr) begin
                    w_state_next = ST_RUN;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_active    = is_counting(r_state);
    assign w_tick      = w_active && (r_ps == PS_LAST);
    assign w_live_next = w_clear ? '0 : (w_tick ? time_inc(r_live) : r_live);

    // Prescaler freezes outside RUN/LAP so a resumed run keeps its partial centisecond
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ps   <= '0;
            r_live <= '0;
        end else begin
            if (w_clear) begin
                r_ps <= '0;
            end else if (w_active) begin
                r_ps <= w_tick ? '0 : r_ps + 1'b1;
            end
            r_live <= w_live_next;
        end
    end

`ifdef STOPWATCH_LAP_EN
    sw_time_t r_disp;

    // Display tracks live time except while staying in LAP; entering LAP captures the value of that edge
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_disp <= '0;
        end else if (!((r_state == ST_LAP) && (w_state_next == ST_LAP))) begin
            r_disp <= w_live_next;
        end
    end

    assign w_disp   = r_disp;
    assign lap_hold = (r_state == ST_LAP);
`else
    assign w_disp   = r_live;
    assign lap_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rf_cnt  <= '0;
            r_refresh <= 1'b0;
        end else if (r_rf_cnt == RF_LAST) begin
            r_rf_cnt  <= '0;
            r_refresh <= ~r_refresh;
        end else begin
            r_rf_cnt <= r_rf_cnt + 1'b1;
        end
    end

    assign hours         = w_disp.hr;
    assign minutes       = w_disp.mn;
    assign seconds       = w_disp.sc;
    assign centiseconds  = w_disp.cs;
    assign clock_refresh = r_refresh;
    assign running       = w_active;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller at CLK_HZ=1000, REFRESH_HZ=100 (10-cycle tick, 5-cycle refresh half-period).
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_stopwatch_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn_ss;
    logic       btn_lr;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] centiseconds;
    logic       clock_refresh;
    logic       running;
    logic       lap_hold;

    stopwatch_controller #(
        .CLK_HZ     (1000),
        .REFRESH_HZ (100)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .btn_start_stop (btn_ss),
        .btn_lap_reset  (btn_lr),
        .hours          (hours),
        .minutes        (minutes),
        .seconds        (seconds),
        .centiseconds   (centiseconds),
        .clock_refresh  (clock_refresh),
        .running        (running),
        .lap_hold       (lap_hold)
    );

    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    hr, mn, sc, cs;
        bit    run, hold;
    } exp_t;

    typedef struct {
        string name;
        bit    ss, lr;
        int    wait_cyc;
        int    hr, mn, sc, cs;
        bit    run, hold;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add_vec(string name, bit ss, bit lr, int w,
                                    int hr, int mn, int sc, int cs, bit run, bit hold);
        vec_t v;
        v.name = name; v.ss = ss; v.lr = lr; v.wait_cyc = w;
        v.hr = hr; v.mn = mn; v.sc = sc; v.cs = cs; v.run = run; v.hold = hold;
        vecs.push_back(v);
    endfunction

    function automatic void expect_out(string name, int hr, int mn, int sc, int cs, bit run, bit hold);
        exp_t e;
        e.name = name; e.hr = hr; e.mn = mn; e.sc = sc; e.cs = cs; e.run = run; e.hold = hold;
        sb_q.push_back(e);
    endfunction

    task automatic check_out();
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e = sb_q.pop_front();
            if (hours == e.hr && minutes == e.mn && seconds == e.sc && centiseconds == e.cs &&
                running === e.run && lap_hold === e.hold) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got %0d:%0d:%0d.%0d run=%0b hold=%0b, want %0d:%0d:%0d.%0d run=%0b hold=%0b",
                         e.name, hours, minutes, seconds, centiseconds, running, lap_hold,
                         e.hr, e.mn, e.sc, e.cs, e.run, e.hold);
            end
        end
    endtask

    // Called at a falling edge: raise for one cycle, return at the next falling edge
    task automatic press(input bit ss, input bit lr);
        btn_ss = ss;
        btn_lr = lr;
        @(negedge clock);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
    endtask

    // Refresh monitor: zero during reset, then a toggle exactly every 5 cycles
    bit   mon_en     = 1'b1;
    bit   rf_rst     = 1'b0;
    logic rf_prev    = 1'b0;
    int   rf_n       = 0;
    int   rf_toggles = 0;

    always @(posedge clock) begin
        rf_rst = !reset_n;
        #1;
        if (mon_en) begin
            if (rf_rst) begin
                n_checks++;
                if (clock_refresh === 1'b0) n_pass++;
                else $display("FAIL refresh_reset: got %b, want 0", clock_refresh);
                rf_n    = 0;
                rf_prev = 1'b0;
            end else begin
                rf_n++;
                if (clock_refresh !== rf_prev) begin
                    n_checks++;
                    if (rf_n == 5) n_pass++;
                    else $display("FAIL refresh_period: toggled after %0d cycles, want 5", rf_n);
                    rf_n = 0;
                    rf_toggles++;
                end else if (rf_n > 5) begin
                    n_checks++;
                    $display("FAIL refresh_stuck: no toggle for %0d cycles, want 5", rf_n);
                    rf_n = 0;
                end
                rf_prev = clock_refresh;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        btn_ss  = 1'b0;
        btn_lr  = 1'b0;

        //       name                ss lr  wait   hr mn sc  cs  run hold
        add_vec("reset",             0, 0, 0,     0, 0, 0,  0,  0, 0);
        add_vec("start_1s",          1, 0, 1001,  0, 0, 1,  0,  1, 0);
        add_vec("run_59_99",         0, 0, 58990, 0, 0, 59, 99, 1, 0);
        add_vec("minute_carry",      0, 0, 10,    0, 1, 0,  0,  1, 0);
        add_vec("pause",             1, 0, 3,     0, 1, 0,  0,  0, 0);
        add_vec("resume_no_tick",    1, 0, 8,     0, 1, 0,  0,  1, 0);
        add_vec("resume_tick",       0, 0, 1,     0, 1, 0,  1,  1, 0);
        add_vec("both_buttons",      1, 1, 3,     0, 1, 0,  1,  0, 0);
        add_vec("pause_clear",       0, 1, 2,     0, 0, 0,  0,  0, 0);
        add_vec("idle_lap_ignored",  0, 1, 3,     0, 0, 0,  0,  0, 0);
        add_vec("restart_no_tick",   1, 0, 10,    0, 0, 0,  0,  1, 0);
        add_vec("restart_tick",      0, 0, 1,     0, 0, 0,  1,  1, 0);
        add_vec("run_to_50",         0, 0, 490,   0, 0, 0,  50, 1, 0);
`ifdef STOPWATCH_LAP_EN
        add_vec("lap_enter",         0, 1, 3,     0, 0, 0,  50, 1, 1);
        add_vec("lap_frozen",        0, 0, 95,    0, 0, 0,  50, 1, 1);
        add_vec("lap_release",       0, 1, 3,     0, 0, 0,  60, 1, 0);
        add_vec("lap_again",         0, 1, 3,     0, 0, 0,  60, 1, 1);
        add_vec("lap_live_counts",   0, 0, 10,    0, 0, 0,  60, 1, 1);
        add_vec("lap_to_pause",      1, 0, 3,     0, 0, 0,  61, 0, 0);
        add_vec("resume_at_ps9",     1, 0, 2,     0, 0, 0,  62, 1, 0);
`else
        add_vec("run_lap_ignored",   0, 1, 3,     0, 0, 0,  50, 1, 0);
        add_vec("still_running",     0, 0, 6,     0, 0, 0,  51, 1, 0);
`endif

        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            expect_out(vecs[i].name, vecs[i].hr, vecs[i].mn, vecs[i].sc, vecs[i].cs,
                       vecs[i].run, vecs[i].hold);
            if (vecs[i].ss || vecs[i].lr) press(vecs[i].ss, vecs[i].lr);
            repeat (vecs[i].wait_cyc) @(negedge clock);
            check_out();
        end

        // Mid-run reset, with a button rising while reset is held
        reset_n = 1'b0;
        btn_ss  = 1'b1;
        expect_out("mid_run_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        check_out();
        btn_ss = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        expect_out("no_cmd_after_reset", 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check_out();

        // Day wrap from a preloaded 23:59:59.99 with the prescaler at 0
        press(1'b1, 1'b0);
        @(negedge clock);
        force dut.r_live = {5'd23, 6'd59, 6'd59, 7'd99};
        #1;
        release dut.r_live;
        expect_out("preload_23_59_59_99", 23, 59, 59, 99, 1, 0);
        repeat (9) @(negedge clock);
        check_out();
        expect_out("day_wrap", 0, 0, 0, 0, 1, 0);
        @(negedge clock);
        check_out();

        repeat (20) @(negedge clock);
        mon_en = 1'b0;
        n_checks++;
        if (rf_toggles > 1000) n_pass++;
        else $display("FAIL refresh_activity: got %0d toggles, want more than 1000", rf_toggles);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
